// File: rtl/ic_pkg.sv
// Shared constants, state encoding and sizing helper for the icache DMA read path.
package ic_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_RD
    } state_t;

    function automatic int beat_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ic_line_buf.sv
// One-burst line buffer: register file with per-beat fill mask and async read.
module ic_line_buf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 128,
    parameter int IW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    output logic [DEPTH-1:0]  mask
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mask <= '0;
        end else begin
            if (clr) mask <= '0;
            else if (we) mask[waddr] <= 1'b1;
            if (we) mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ic_dma_rd.sv
// Icache DMA read responder: serves beats from a one-burst window, refills via AXI4 INCR.
module ic_dma_rd
    import ic_pkg::*;
#(
    parameter int ADDR_W    = 33,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_valid,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_data,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              rd_err
);

    localparam int IW  = beat_idx_w(BURST_LEN);
    localparam int LSB = IW + 4;
    localparam int BW  = ADDR_W - LSB;

    state_t               state;
    logic [BW-1:0]        base;
    logic                 win_valid;
    logic [IW-1:0]        k;
    logic [BURST_LEN-1:0] mask;
    logic [DATA_W-1:0]    buf_data;

    logic [BW-1:0] req_base;
    logic [IW-1:0] req_beat;
    logic          req, beat, fill, bypass, hit, miss, clr;
    logic          unused;

    assign req_base = dma_addr[ADDR_W-1:LSB];
    assign req_beat = dma_addr[LSB-1:4];
    assign unused   = ^dma_addr[3:0];

    // The cycle carrying an ack still sees the old request held high.
    assign req    = dma_valid && !dma_ack && !flush;
    assign beat   = m_axi_rvalid && m_axi_rready;
    assign fill   = beat && win_valid && !flush;
    assign bypass = fill && (k == req_beat);
    assign hit    = req && win_valid && (base == req_base)
                    && (mask[req_beat] || bypass);
    assign miss   = req && !hit && (state == ST_IDLE);
    assign clr    = flush || miss;

    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = AXI_SIZE_16B;
    assign m_axi_arburst = AXI_BURST_INCR;

    ic_line_buf #(
        .DEPTH (BURST_LEN),
        .DATA_W(DATA_W),
        .IW    (IW)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .we   (fill),
        .waddr(k),
        .wdata(m_axi_rdata),
        .raddr(req_beat),
        .rdata(buf_data),
        .mask (mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            dma_ack       <= 1'b0;
            dma_data      <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
            rd_err        <= 1'b0;
            win_valid     <= 1'b0;
            base          <= '0;
            k             <= '0;
        end else begin
            dma_ack <= hit;
            if (hit) dma_data <= bypass ? m_axi_rdata : buf_data;
            if (beat && m_axi_rresp != AXI_RESP_OKAY) rd_err <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (miss) begin
                        m_axi_araddr  <= {req_base, {LSB{1'b0}}};
                        m_axi_arvalid <= 1'b1;
                        base          <= req_base;
                        win_valid     <= 1'b1;
                        state         <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        k             <= '0;
                        state         <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (beat) begin
                        k <= k + IW'(1);
                        if (m_axi_rlast) begin
                            m_axi_rready <= 1'b0;
                            k            <= '0;
                            state        <= ST_IDLE;
                            if (k != IW'(BURST_LEN - 1)) rd_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Flush wins over any error raised in the same cycle.
            if (flush) begin
                win_valid <= 1'b0;
                rd_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ic_dma_rd.sv
// Randomised bench for ic_dma_rd: AXI slave + memory model, cycle-level reference checks.
module tb_ic_dma_rd;

    localparam int AW = 33;
    localparam int DW = 128;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_valid = 1'b0;
    logic          dma_ack;
    logic [DW-1:0] dma_data;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          rd_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ic_dma_rd #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .dma_addr     (dma_addr),
        .dma_valid    (dma_valid),
        .dma_ack      (dma_ack),
        .dma_data     (dma_data),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .rd_err       (rd_err)
    );

    // Backing memory: every 16-byte beat has a distinct pattern.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {3'b000, a[AW-1:4]};
        return {w ^ 32'hA5A5_5A5A, ~w, w * 32'h9E37_79B1, w + 32'h0BAD_F00D};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- AXI read slave ----------------
    int            ar_rate = 100;
    int            rv_rate = 100;
    int            err_beat = -1;
    int            err_pct = 0;
    int            burst_beats = BL;
    bit            s_active = 1'b0;
    int            s_beat = 0;
    logic [AW-1:0] s_addr = '0;
    logic [AW-1:0] ar_q[$];
    bit            s_arf, s_rf;
    logic [AW-1:0] s_a;

    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            s_arf = m_axi_arvalid && m_axi_arready;
            s_rf  = m_axi_rvalid && m_axi_rready;
            s_a   = m_axi_araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_active      = 1'b0;
                s_beat        = 0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_arready = 1'b0;
            end else begin
                if (s_arf) begin
                    s_active = 1'b1;
                    s_beat   = 0;
                    s_addr   = s_a;
                    ar_q.push_back(s_a);
                end
                if (s_rf) begin
                    if (m_axi_rlast) s_active = 1'b0;
                    s_beat++;
                    m_axi_rvalid = 1'b0;
                end
                m_axi_arready = ($urandom_range(99) < ar_rate);
                if (s_active && !m_axi_rvalid && $urandom_range(99) < rv_rate) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = mem_f(s_addr + AW'(16 * s_beat));
                    m_axi_rlast  = (s_beat == burst_beats - 1);
                    m_axi_rresp  = (s_beat == err_beat || $urandom_range(99) < err_pct)
                                   ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit            e_ack, e_arv, e_rr, e_err;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_araddr;
    int            phase;     // 0 bus free, 1 address phase, 2 data phase
    bit            w_valid;
    logic [AW-8:0] w_base;
    bit [BL-1:0]   w_mask;
    int            cnt;
    bit            ar_hs, r_hs, m_req, m_hit, n_ack;
    logic [AW-8:0] rb;
    int            ri;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_ack = 0; e_arv = 0; e_rr = 0; e_err = 0;
            e_data = '0; e_araddr = '0;
            phase = 0; w_valid = 0; w_base = '0; w_mask = '0; cnt = 0;
        end else begin
            chk("dma_ack", dma_ack, e_ack);
            if (e_ack) chk("dma_data", dma_data, e_data);
            chk("arvalid", m_axi_arvalid, e_arv);
            if (e_arv) chk("araddr", m_axi_araddr, e_araddr);
            chk("rready", m_axi_rready, e_rr);
            chk("rd_err", rd_err, e_err);

            ar_hs = e_arv && m_axi_arready;
            r_hs  = e_rr && m_axi_rvalid;
            rb    = dma_addr[AW-1:7];
            ri    = int'(dma_addr[6:4]);
            m_req = dma_valid && !e_ack && !flush;
            m_hit = m_req && w_valid && (w_base == rb)
                    && (w_mask[ri] || (r_hs && cnt == ri));
            n_ack = m_hit;
            if (m_hit) e_data = mem_f(dma_addr);
            if (phase == 0 && m_req && !m_hit) begin
                e_arv = 1; e_araddr = {rb, 7'b0};
                w_base = rb; w_valid = 1; w_mask = '0; phase = 1;
            end
            if (ar_hs) begin
                e_arv = 0; e_rr = 1; cnt = 0; phase = 2;
            end
            if (r_hs) begin
                if (w_valid && !flush) w_mask[cnt] = 1'b1;
                if (m_axi_rresp != 2'b00) e_err = 1;
                if (m_axi_rlast) begin
                    if (cnt != BL - 1) e_err = 1;
                    e_rr = 0; phase = 0; cnt = 0;
                end else begin
                    cnt++;
                end
            end
            if (flush) begin
                w_valid = 0; w_mask = '0; e_err = 0;
            end
            e_ack = n_ack;
        end
    end

    // ---------------- cache-side driver ----------------
    task automatic do_req(input logic [AW-1:0] a, output int lat);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        dma_valid = 1'b1;
        dma_addr  = a;
        do begin
            @(negedge clk);
            n++;
        end while (!dma_ack && n < 400);
        if (!dma_ack) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout %h: no ack in %0d cycles, ack required", a, n);
        end
        lat = n - 1;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        dma_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic flush_pulse();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_beats(input int b);
        int n;
        n = 0;
        while (s_beat < b && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (s_beat < b) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_wait: reached beat %0d, required %0d", s_beat, b);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ack"}, dma_ack, 0);
        chk({tag, "_data"}, dma_data, 0);
        chk({tag, "_arvalid"}, m_axi_arvalid, 0);
        chk({tag, "_araddr"}, m_axi_araddr, 0);
        chk({tag, "_rready"}, m_axi_rready, 0);
        chk({tag, "_rd_err"}, rd_err, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, completion required");
        $fatal(1);
    end

    initial begin
        int lat;
        int g;
        logic [AW-1:0] a;

        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        chk("arlen", m_axi_arlen, 7);
        chk("arsize", m_axi_arsize, 3'b100);
        chk("arburst", m_axi_arburst, 2'b01);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // cold sequential stream
        ar_q.delete();
        for (int i = 0; i < 16; i++) do_req(33'h1000 + AW'(16 * i), lat);
        idle(4);
        chk("cold_ar_count", ar_q.size(), 2);
        if (ar_q.size() >= 2) begin
            chk("cold_ar0", ar_q[0], 33'h1000);
            chk("cold_ar1", ar_q[1], 33'h1080);
        end

        // hit latency
        do_req(33'h2000, lat);
        idle(15);
        do_req(33'h2030, lat);
        chk("hit_latency", lat, 1);
        chk("hit_data", dma_data, mem_f(33'h2030));
        idle(2);

        // miss while a burst is in flight
        ar_q.delete();
        do_req(33'h3000, lat);
        do_req(33'h4000, lat);
        chk("miss_rd_data", dma_data, mem_f(33'h4000));
        idle(12);
        chk("miss_rd_ar_count", ar_q.size(), 2);
        if (ar_q.size() >= 2) chk("miss_rd_ar1", ar_q[1], 33'h4000);

        // flush mid-burst
        rv_rate = 40;
        ar_q.delete();
        do_req(33'h5000, lat);
        idle(1);
        wait_beats(3);
        flush_pulse();
        do_req(33'h5060, lat);
        chk("flush_data", dma_data, mem_f(33'h5060));
        idle(20);
        chk("flush_ar_count", ar_q.size(), 2);
        if (ar_q.size() >= 2) chk("flush_fresh_ar", ar_q[1], 33'h5000);
        rv_rate = 100;

        // error response on beat 5
        err_beat = 5;
        do_req(33'h6050, lat);
        chk("err_beat_data", dma_data, mem_f(33'h6050));
        idle(12);
        chk("rd_err_set", rd_err, 1);
        err_beat = -1;
        flush_pulse();
        @(negedge clk);
        chk("rd_err_clr", rd_err, 0);

        // early rlast
        ar_q.delete();
        burst_beats = 4;
        do_req(33'h7010, lat);
        idle(10);
        chk("short_burst_err", rd_err, 1);
        burst_beats = BL;
        do_req(33'h7060, lat);
        idle(12);
        chk("short_reissue_count", ar_q.size(), 2);
        if (ar_q.size() >= 2) chk("short_reissue_ar", ar_q[1], 33'h7000);
        flush_pulse();

        // randomised traffic
        err_pct = 5;
        a = 33'h1_0000_0000;
        for (int i = 0; i < 150; i++) begin
            ar_rate = 30 + $urandom_range(70);
            rv_rate = 30 + $urandom_range(70);
            if ($urandom_range(99) < 60) a = a + AW'(16);
            else a = (AW'($urandom_range(1)) << 32) | (AW'($urandom_range(3)) << 12)
                     | (AW'($urandom_range(31)) << 4) | AW'($urandom_range(15));
            do_req(a, lat);
            g = $urandom_range(3);
            if (g > 0) idle(g);
            if ($urandom_range(14) == 0) begin
                idle(1);
                flush_pulse();
            end
        end
        idle(30);
        err_pct = 0;
        ar_rate = 100;
        flush_pulse();

        // asynchronous reset during a burst
        rv_rate = 30;
        do_req(33'h8000, lat);
        idle(1);
        wait_beats(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        dma_valid = 1'b0;
        #1 chk_reset_outs("async_rst");
        repeat (3) @(posedge clk);
        rv_rate = 100;
        ar_q.delete();
        #3 rst_n = 1'b1;
        do_req(33'h9000, lat);
        chk("post_rst_data", dma_data, mem_f(33'h9000));
        idle(12);
        chk("post_rst_ar_count", ar_q.size(), 1);
        if (ar_q.size() >= 1) chk("post_rst_ar", ar_q[0], 33'h9000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
